letc_core_stage_e1: RTL and testbench
=====================================

# letc_core_stage_e1

First execute stage of the LETC core pipeline, sitting between decode (D) and the second execute stage (E2). It selects operands for the single-cycle integer ALU and resolves conditional branches and jumps. It captures the ALU result and the writeback/store payload into a valid/ready pipeline register toward E2, and issues a one-cycle fetch redirect when a control transfer is taken.

## Interface
- No parameters; widths come from `letc_pkg`, `letc_core_pkg` and `riscv_pkg` (`word_t` = 32 bits, `alu_op_e`).
- `clk`  in  1  core clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_flush`  in  1  squash the E1 input and E2 register (trap/exception path).
- `i_d_valid` / `o_d_ready`  in/out  1  D→E1 handshake.
- `i_d_pc`, `i_d_rs1_val`, `i_d_rs2_val`, `i_d_imm`  in  32 each  decoded payload.
- `i_d_rs1_idx`, `i_d_rs2_idx`, `i_d_rd_idx`  in  5 each  register indices.
- `i_d_rd_we`  in  1  instruction writes rd.
- `i_d_op1_src`  in  2  0=rs1, 1=pc, 2=zero; 3 is reserved and drives 0.
- `i_d_op2_src`  in  1  0=rs2, 1=imm.
- `i_d_alu_op`  in  `alu_op_e`  ALU operation.
- `i_d_ctrl`  in  3  0=none, 1=jal, 2=jalr, 3=beq, 4=bne, 5=blt, 6=bge, 7=bltu/bgeu. The bltu/bgeu choice is made by `i_d_imm_funct0`.
- `i_d_imm_funct0`  in  1  unsigned-compare polarity for ctrl=7: 0=bltu, 1=bgeu.
- `o_alu_operands`  out  2×32  to the ALU.
- `o_alu_operation`  out  `alu_op_e`  to the ALU.
- `i_alu_result`  in  32  from the ALU (combinational).
- `o_e2_valid` / `i_e2_ready`  out/in  1  E1→E2 handshake.
- `o_e2_wb_val`  out  32  value for rd.
- `o_e2_store_data`  out  32  forwarded rs2 value.
- `o_e2_rd_idx`  out  5  destination register index.
- `o_e2_rd_we`  out  1  rd write enable.
- `o_redirect_valid`  out  1  one-cycle pulse requesting a fetch redirect.
- `o_redirect_pc`  out  32  redirect target.

## Operation
- **Operand selection:** operand 0 per `i_d_op1_src`; operand 1 per `i_d_op2_src`. The result passes straight to the ALU.
- **Control transfers:** for branches and jal, decode sets op1=pc, op2=imm, ADD, so `i_alu_result` is the target. For jalr, op1=rs1, op2=imm, and the target is `i_alu_result & ~32'h1`.
- **Branch compare:** performed locally on the (bypassed) rs1/rs2 values, not in the ALU. blt/bge compare signed; bltu/bgeu compare unsigned.
- **Writeback value:** `o_e2_wb_val` = pc+4 (modulo 2^32) for jal/jalr, otherwise `i_alu_result`. Branches force `o_e2_rd_we`=0.
- **Accept condition:** accept = `i_d_valid && o_d_ready && !i_flush && !o_redirect_valid`. The cycle after a taken redirect is a self-squash: input in that cycle is consumed and dropped.
- **Register updates:**
  - On accept, the E2 register loads the payload and sets valid.
  - If there is no accept but `i_e2_ready` is high, valid clears.
  - Otherwise the register holds its contents.
- **Redirect:** `o_redirect_valid` is registered, set for exactly one cycle after an accepted taken branch/jal/jalr, with `o_redirect_pc` = the target.
- **Flush:** when `i_flush` is high, next cycle `o_e2_valid`=0 and `o_redirect_valid`=0. Flush overrides a simultaneous accept.
- **Misaligned targets:** not checked here; E2/trap logic owns them.

## Timing
- Latency is 1 cycle from D accept to `o_e2_valid`. Throughput is 1 instruction per cycle when `i_e2_ready`=1.
- `o_d_ready = !o_e2_valid || i_e2_ready`. This is combinational from `i_e2_ready` only and has no dependence on `i_d_valid`.
- E2 payload is stable while `o_e2_valid && !i_e2_ready`.
- Once `i_d_valid` is asserted it is held until accepted or flushed.
- **Reset** (`rst_n` low at the clock edge):
  - `o_e2_valid`=0 and `o_redirect_valid`=0.
  - All E2 payload registers and `o_redirect_pc` = 0.
  - Reset overrides all other inputs, including mid-stall.
- **ALU path:** `o_alu_operands` and `o_alu_operation` are combinational from D inputs. They are don't-care when `i_d_valid`=0.

## Configuration
- **`LETC_CORE_E1_BYPASS_EN` defined:** the rs1/rs2 values used for operands, compare and store data are replaced by `o_e2_wb_val` when all of the following hold:
  - `o_e2_valid` and `o_e2_rd_we` are set;
  - `o_e2_rd_idx` != 0;
  - `o_e2_rd_idx` equals the source index.
- **Not defined:** no bypass. The rs index inputs are unused, and decode must stall on any RAW hazard against E1/E2.

## Test plan
- **ADDI:** rs1=5, imm=7, op2=imm, ADD → next cycle `o_e2_valid`=1, wb_val=12, rd_we=1, no redirect.
- **Backpressure:** hold `i_e2_ready`=0 with the register full → `o_d_ready`=0 and the payload is stable for 5 cycles. Raise ready → same cycle `o_d_ready`=1, and the next instruction loads.
- **Taken beq:** pc=0x100, imm=0x20, rs1=rs2=3 → `o_redirect_valid` pulses 1 cycle with pc=0x120, rd_we=0. An instruction offered the following cycle is dropped.
- **jalr:** rs1=0x203, imm=0, pc=0x40 → redirect pc=0x202, wb_val=0x44.
- **Simultaneous events:** `i_flush` with accept of a taken branch → `o_e2_valid`=0 and no redirect. Reset asserted while stalled full → all outputs 0 next cycle.
- **Bypass (with `LETC_CORE_E1_BYPASS_EN`):** E2 holds rd=x5, wb_val=9; E1 `add x6,x5,x5` → wb_val=18. Without the macro → uses `i_d_rs1_val`.

Source files
------------

// File: rtl/letc_core_stage_e1.sv
// LETC core E1 stage: operand select, branch resolve and the E1->E2 pipeline register.
// Define LETC_CORE_E1_BYPASS_EN to forward the E2 writeback value into rs1/rs2.
package letc_core_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9
    } alu_op_e;
endpackage

module letc_core_stage_e1
    import letc_core_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_d_valid,
    output logic             o_d_ready,
    input  word_t            i_d_pc,
    input  word_t            i_d_rs1_val,
    input  word_t            i_d_rs2_val,
    input  word_t            i_d_imm,
    input  logic [4:0]       i_d_rs1_idx,
    input  logic [4:0]       i_d_rs2_idx,
    input  logic [4:0]       i_d_rd_idx,
    input  logic             i_d_rd_we,
    input  logic [1:0]       i_d_op1_src,
    input  logic             i_d_op2_src,
    input  alu_op_e          i_d_alu_op,
    input  logic [2:0]       i_d_ctrl,
    input  logic             i_d_imm_funct0,
    output word_t [1:0]      o_alu_operands,
    output alu_op_e          o_alu_operation,
    input  word_t            i_alu_result,
    output logic             o_e2_valid,
    input  logic             i_e2_ready,
    output word_t            o_e2_wb_val,
    output word_t            o_e2_store_data,
    output logic [4:0]       o_e2_rd_idx,
    output logic             o_e2_rd_we,
    output logic             o_redirect_valid,
    output word_t            o_redirect_pc
);
    logic       e2Valid_q, e2Valid_d;
    word_t      wbVal_q, wbVal_d;
    word_t      storeData_q, storeData_d;
    logic [4:0] rdIdx_q, rdIdx_d;
    logic       rdWe_q, rdWe_d;
    logic       redirValid_q, redirValid_d;
    word_t      redirPc_q, redirPc_d;

    word_t rs1Val, rs2Val, target;
    logic  isJump, isBranch, taken, accept;

`ifdef LETC_CORE_E1_BYPASS_EN
    logic bypassAllowed;
    assign bypassAllowed = e2Valid_q && rdWe_q && (rdIdx_q != 5'd0);
    assign rs1Val = (bypassAllowed && (rdIdx_q == i_d_rs1_idx)) ? wbVal_q : i_d_rs1_val;
    assign rs2Val = (bypassAllowed && (rdIdx_q == i_d_rs2_idx)) ? wbVal_q : i_d_rs2_val;
`else
    logic unusedRsIdx;
    assign unusedRsIdx = ^{i_d_rs1_idx, i_d_rs2_idx};
    assign rs1Val = i_d_rs1_val;
    assign rs2Val = i_d_rs2_val;
`endif

    always_comb begin
        o_alu_operands = '0;
        unique case (i_d_op1_src)
            2'd0:    o_alu_operands[0] = rs1Val;
            2'd1:    o_alu_operands[0] = i_d_pc;
            default: o_alu_operands[0] = '0;
        endcase
        o_alu_operands[1] = i_d_op2_src ? i_d_imm : rs2Val;
    end

    assign o_alu_operation = i_d_alu_op;

    // Branch compare uses the source values directly; the ALU is busy computing the target.
    always_comb begin
        taken = 1'b0;
        unique case (i_d_ctrl)
            3'd1, 3'd2: taken = 1'b1;
            3'd3:       taken = (rs1Val == rs2Val);
            3'd4:       taken = (rs1Val != rs2Val);
            3'd5:       taken = ($signed(rs1Val) <  $signed(rs2Val));
            3'd6:       taken = ($signed(rs1Val) >= $signed(rs2Val));
            3'd7:       taken = i_d_imm_funct0 ? (rs1Val >= rs2Val) : (rs1Val < rs2Val);
            default:    taken = 1'b0;
        endcase
    end

    assign isJump   = (i_d_ctrl == 3'd1) || (i_d_ctrl == 3'd2);
    assign isBranch = (i_d_ctrl >= 3'd3);
    assign target   = (i_d_ctrl == 3'd2) ? (i_alu_result & ~32'h1) : i_alu_result;

    assign o_d_ready = !e2Valid_q || i_e2_ready;
    assign accept    = i_d_valid && o_d_ready && !i_flush && !redirValid_q;

    always_comb begin
        e2Valid_d    = e2Valid_q;
        wbVal_d      = wbVal_q;
        storeData_d  = storeData_q;
        rdIdx_d      = rdIdx_q;
        rdWe_d       = rdWe_q;
        redirValid_d = 1'b0;
        redirPc_d    = redirPc_q;
        if (accept) begin
            e2Valid_d   = 1'b1;
            wbVal_d     = isJump ? (i_d_pc + 32'd4) : i_alu_result;
            storeData_d = rs2Val;
            rdIdx_d     = i_d_rd_idx;
            rdWe_d      = i_d_rd_we && !isBranch;
            if (taken) begin
                redirValid_d = 1'b1;
                redirPc_d    = target;
            end
        end else if (i_e2_ready) begin
            e2Valid_d = 1'b0;
        end
        if (i_flush) begin
            e2Valid_d    = 1'b0;
            redirValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e2Valid_q    <= 1'b0;
            wbVal_q      <= '0;
            storeData_q  <= '0;
            rdIdx_q      <= '0;
            rdWe_q       <= 1'b0;
            redirValid_q <= 1'b0;
            redirPc_q    <= '0;
        end else begin
            e2Valid_q    <= e2Valid_d;
            wbVal_q      <= wbVal_d;
            storeData_q  <= storeData_d;
            rdIdx_q      <= rdIdx_d;
            rdWe_q       <= rdWe_d;
            redirValid_q <= redirValid_d;
            redirPc_q    <= redirPc_d;
        end
    end

    assign o_e2_valid       = e2Valid_q;
    assign o_e2_wb_val      = wbVal_q;
    assign o_e2_store_data  = storeData_q;
    assign o_e2_rd_idx      = rdIdx_q;
    assign o_e2_rd_we       = rdWe_q;
    assign o_redirect_valid = redirValid_q;
    assign o_redirect_pc    = redirPc_q;
endmodule

// File: tb/tb_letc_core_stage_e1.sv
// Testbench for letc_core_stage_e1: directed scenarios plus randomized traffic
// checked every cycle against an instruction-level reference model.
module tb_letc_core_stage_e1;
    import letc_core_pkg::*;

`ifdef LETC_CORE_E1_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_flush;
    logic       i_d_valid;
    logic       o_d_ready;
    word_t      i_d_pc, i_d_rs1_val, i_d_rs2_val, i_d_imm;
    logic [4:0] i_d_rs1_idx, i_d_rs2_idx, i_d_rd_idx;
    logic       i_d_rd_we;
    logic [1:0] i_d_op1_src;
    logic       i_d_op2_src;
    alu_op_e    i_d_alu_op;
    logic [2:0] i_d_ctrl;
    logic       i_d_imm_funct0;
    word_t [1:0] o_alu_operands;
    alu_op_e    o_alu_operation;
    word_t      i_alu_result;
    logic       o_e2_valid;
    logic       i_e2_ready;
    word_t      o_e2_wb_val, o_e2_store_data;
    logic [4:0] o_e2_rd_idx;
    logic       o_e2_rd_we;
    logic       o_redirect_valid;
    word_t      o_redirect_pc;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    letc_core_stage_e1 dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
        .i_d_valid(i_d_valid), .o_d_ready(o_d_ready),
        .i_d_pc(i_d_pc), .i_d_rs1_val(i_d_rs1_val), .i_d_rs2_val(i_d_rs2_val), .i_d_imm(i_d_imm),
        .i_d_rs1_idx(i_d_rs1_idx), .i_d_rs2_idx(i_d_rs2_idx), .i_d_rd_idx(i_d_rd_idx),
        .i_d_rd_we(i_d_rd_we), .i_d_op1_src(i_d_op1_src), .i_d_op2_src(i_d_op2_src),
        .i_d_alu_op(i_d_alu_op), .i_d_ctrl(i_d_ctrl), .i_d_imm_funct0(i_d_imm_funct0),
        .o_alu_operands(o_alu_operands), .o_alu_operation(o_alu_operation),
        .i_alu_result(i_alu_result),
        .o_e2_valid(o_e2_valid), .i_e2_ready(i_e2_ready),
        .o_e2_wb_val(o_e2_wb_val), .o_e2_store_data(o_e2_store_data),
        .o_e2_rd_idx(o_e2_rd_idx), .o_e2_rd_we(o_e2_rd_we),
        .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc)
    );

    always #5 clk = ~clk;

    // Reference model state: what E2 and the redirect port must hold right now.
    bit    mValid = 0, mWe = 0, mRedir = 0, mConsumed = 1;
    word_t mWb = 0, mStore = 0, mRedirPc = 0;
    logic [4:0] mRd = 0;

    word_t expRs1, expRs2, expOp0, expOp1;
    bit    expReady;

    function automatic word_t aluModel(word_t a, word_t b, alu_op_e op);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_SLL:  return a << b[4:0];
            ALU_OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SRL:  return a >> b[4:0];
            ALU_OP_SRA:  return word_t'($signed(a) >>> b[4:0]);
            ALU_OP_OR:   return a | b;
            ALU_OP_AND:  return a & b;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic bit brTaken(logic [2:0] ctrl, logic f0, word_t a, word_t b);
        int sa = a;
        int sb = b;
        case (ctrl)
            3'd1, 3'd2: return 1'b1;
            3'd3:       return a == b;
            3'd4:       return a != b;
            3'd5:       return sa < sb;
            3'd6:       return !(sa < sb);
            3'd7:       return f0 ? !(a < b) : (a < b);
            default:    return 1'b0;
        endcase
    endfunction

    // Environment view of the source values and the ALU sitting beside E1.
    always_comb begin
        expRs1 = i_d_rs1_val;
        expRs2 = i_d_rs2_val;
        if (BYPASS && mValid && mWe && mRd != 5'd0) begin
            if (mRd == i_d_rs1_idx) expRs1 = mWb;
            if (mRd == i_d_rs2_idx) expRs2 = mWb;
        end
        expOp0 = (i_d_op1_src == 2'd0) ? expRs1 : (i_d_op1_src == 2'd1) ? i_d_pc : 32'd0;
        expOp1 = i_d_op2_src ? i_d_imm : expRs2;
        expReady = !mValid || i_e2_ready;
        i_alu_result = aluModel(expOp0, expOp1, i_d_alu_op);
    end

    // Model update: decide fate of the offered instruction from the rules, commit with <=.
    always @(posedge clk) begin
        bit acc, tk, jmp;
        acc = i_d_valid && expReady && !i_flush && !mRedir;
        tk  = brTaken(i_d_ctrl, i_d_imm_funct0, expRs1, expRs2);
        jmp = (i_d_ctrl == 3'd1) || (i_d_ctrl == 3'd2);
        if (!rst_n) begin
            mValid <= 0; mWb <= 0; mStore <= 0; mRd <= 0; mWe <= 0;
            mRedir <= 0; mRedirPc <= 0; mConsumed <= 1;
        end else begin
            mConsumed <= i_d_valid && (expReady || i_flush);
            mRedir    <= acc && tk;
            if (acc) begin
                mValid <= !i_flush;
                mWb    <= jmp ? i_d_pc + 32'd4 : i_alu_result;
                mStore <= expRs2;
                mRd    <= i_d_rd_idx;
                mWe    <= i_d_rd_we && (i_d_ctrl < 3'd3);
                if (tk) mRedirPc <= (i_d_ctrl == 3'd2) ? (i_alu_result & ~32'h1) : i_alu_result;
            end else if (i_e2_ready || i_flush) begin
                mValid <= 0;
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("e2_valid", 32'(o_e2_valid), 32'(mValid));
            checkOutput("redirect_valid", 32'(o_redirect_valid), 32'(mRedir));
            checkOutput("redirect_pc", o_redirect_pc, mRedirPc);
            checkOutput("d_ready", 32'(o_d_ready), 32'(expReady));
            checkOutput("wb_val", o_e2_wb_val, mWb);
            checkOutput("store_data", o_e2_store_data, mStore);
            checkOutput("rd_idx", 32'(o_e2_rd_idx), 32'(mRd));
            checkOutput("rd_we", 32'(o_e2_rd_we), 32'(mWe));
            if (i_d_valid) begin
                checkOutput("alu_op0", o_alu_operands[0], expOp0);
                checkOutput("alu_op1", o_alu_operands[1], expOp1);
                checkOutput("alu_operation", 32'(o_alu_operation), 32'(i_d_alu_op));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setInstr(word_t pc, word_t rs1, word_t rs2, word_t imm,
                            logic [4:0] rs1Idx, logic [4:0] rs2Idx, logic [4:0] rd, logic we,
                            logic [1:0] op1, logic op2, alu_op_e op, logic [2:0] ctrl, logic f0);
        i_d_valid = 1'b1;
        i_d_pc = pc; i_d_rs1_val = rs1; i_d_rs2_val = rs2; i_d_imm = imm;
        i_d_rs1_idx = rs1Idx; i_d_rs2_idx = rs2Idx; i_d_rd_idx = rd; i_d_rd_we = we;
        i_d_op1_src = op1; i_d_op2_src = op2; i_d_alu_op = op; i_d_ctrl = ctrl;
        i_d_imm_funct0 = f0;
    endtask

    task automatic randInstr();
        logic [2:0] ctrl;
        word_t rs1, rs2;
        ctrl = 3'($urandom_range(7));
        rs1 = ($urandom_range(3) == 0) ? $urandom : word_t'($urandom_range(8)) - 32'd4;
        rs2 = ($urandom_range(3) == 0) ? rs1 : word_t'($urandom_range(8)) - 32'd4;
        if (ctrl == 3'd0)
            setInstr($urandom & ~32'h3, rs1, rs2, $urandom_range(64), 5'($urandom_range(7)),
                     5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom),
                     2'($urandom_range(3)), 1'($urandom), alu_op_e'($urandom_range(9)), ctrl, 1'b0);
        else
            setInstr($urandom & ~32'h3, rs1, rs2, $urandom_range(255) << 1, 5'($urandom_range(7)),
                     5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom),
                     (ctrl == 3'd2) ? 2'd0 : 2'd1, 1'b1, ALU_OP_ADD, ctrl, 1'($urandom));
        i_d_valid = ($urandom_range(3) != 0);
    endtask

    task automatic applyStimulus(int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (!i_d_valid || mConsumed) randInstr();
            i_e2_ready = ($urandom_range(3) != 0);
            i_flush    = ($urandom_range(15) == 0);
            rst_n      = ($urandom_range(63) != 0);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; i_flush = 1'b0; i_e2_ready = 1'b1;
        setInstr(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1'b0, ALU_OP_ADD, 3'd0, 1'b0);
        i_d_valid = 1'b0;
        tick();
        started = 1'b1;
        tick();
        checkOutput("reset_valid", 32'(o_e2_valid), 32'd0);
        checkOutput("reset_redirect", 32'(o_redirect_valid), 32'd0);
        rst_n = 1'b1;

        $display("[TB] ADDI");
        setInstr(32'h0, 32'd5, 32'd0, 32'd7, 5'd1, 5'd0, 5'd1, 1'b1, 2'd0, 1'b1, ALU_OP_ADD, 3'd0, 1'b0);
        tick();
        checkOutput("addi_valid", 32'(o_e2_valid), 32'd1);
        checkOutput("addi_wb", o_e2_wb_val, 32'd12);
        checkOutput("addi_we", 32'(o_e2_rd_we), 32'd1);
        checkOutput("addi_redirect", 32'(o_redirect_valid), 32'd0);

        $display("[TB] backpressure");
        i_e2_ready = 1'b0;
        setInstr(32'h4, 32'd1, 32'd0, 32'd1, 5'd1, 5'd0, 5'd2, 1'b1, 2'd0, 1'b1, ALU_OP_ADD, 3'd0, 1'b0);
        #1;
        checkOutput("bp_ready_low", 32'(o_d_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_hold_wb", o_e2_wb_val, 32'd12);
            checkOutput("bp_hold_valid", 32'(o_e2_valid), 32'd1);
        end
        i_e2_ready = 1'b1;
        #1;
        checkOutput("bp_ready_high", 32'(o_d_ready), 32'd1);
        tick();
        checkOutput("bp_next_wb", o_e2_wb_val, 32'd2);
        checkOutput("bp_next_rd", 32'(o_e2_rd_idx), 32'd2);
        i_d_valid = 1'b0;
        tick();

        $display("[TB] taken beq");
        setInstr(32'h100, 32'd3, 32'd3, 32'h20, 5'd1, 5'd2, 5'd0, 1'b1, 2'd1, 1'b1, ALU_OP_ADD, 3'd3, 1'b0);
        tick();
        checkOutput("beq_redirect", 32'(o_redirect_valid), 32'd1);
        checkOutput("beq_pc", o_redirect_pc, 32'h120);
        checkOutput("beq_we", 32'(o_e2_rd_we), 32'd0);
        setInstr(32'h104, 32'h55, 32'd0, 32'd0, 5'd1, 5'd0, 5'd3, 1'b1, 2'd0, 1'b1, ALU_OP_ADD, 3'd0, 1'b0);
        tick();
        checkOutput("squash_valid", 32'(o_e2_valid), 32'd0);
        checkOutput("squash_redirect", 32'(o_redirect_valid), 32'd0);
        i_d_valid = 1'b0;

        $display("[TB] jalr");
        setInstr(32'h40, 32'h203, 32'd0, 32'd0, 5'd1, 5'd0, 5'd1, 1'b1, 2'd0, 1'b1, ALU_OP_ADD, 3'd2, 1'b0);
        tick();
        checkOutput("jalr_pc", o_redirect_pc, 32'h202);
        checkOutput("jalr_wb", o_e2_wb_val, 32'h44);
        checkOutput("jalr_redirect", 32'(o_redirect_valid), 32'd1);
        i_d_valid = 1'b0;
        tick();

        $display("[TB] flush with taken branch");
        setInstr(32'h200, 32'd1, 32'd1, 32'h40, 5'd1, 5'd2, 5'd0, 1'b0, 2'd1, 1'b1, ALU_OP_ADD, 3'd3, 1'b0);
        i_flush = 1'b1;
        tick();
        checkOutput("flush_valid", 32'(o_e2_valid), 32'd0);
        checkOutput("flush_redirect", 32'(o_redirect_valid), 32'd0);
        i_flush = 1'b0;

        $display("[TB] reset while stalled");
        setInstr(32'h8, 32'd20, 32'd6, 32'd1, 5'd1, 5'd2, 5'd4, 1'b1, 2'd0, 1'b1, ALU_OP_ADD, 3'd0, 1'b0);
        tick();
        i_d_valid = 1'b0; i_e2_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("rst_valid", 32'(o_e2_valid), 32'd0);
        checkOutput("rst_wb", o_e2_wb_val, 32'd0);
        checkOutput("rst_store", o_e2_store_data, 32'd0);
        checkOutput("rst_redirect_pc", o_redirect_pc, 32'd0);
        rst_n = 1'b1; i_e2_ready = 1'b1;

        $display("[TB] bypass");
        setInstr(32'h10, 32'd9, 32'd0, 32'd0, 5'd1, 5'd0, 5'd5, 1'b1, 2'd0, 1'b1, ALU_OP_ADD, 3'd0, 1'b0);
        tick();
        setInstr(32'h14, 32'd1, 32'd2, 32'd0, 5'd5, 5'd5, 5'd6, 1'b1, 2'd0, 1'b0, ALU_OP_ADD, 3'd0, 1'b0);
        tick();
        checkOutput("bypass_wb", o_e2_wb_val, BYPASS ? 32'd18 : 32'd3);
        checkOutput("bypass_store", o_e2_store_data, BYPASS ? 32'd9 : 32'd2);
        i_d_valid = 1'b0;
        tick();

        $display("[TB] random traffic");
        applyStimulus(3000);
        rst_n = 1'b1; i_flush = 1'b0; i_d_valid = 1'b0;
        tick();
        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
